z_core_mem_arbiter: RTL and testbench
=====================================

Name: z_core_mem_arbiter

Overview:
- Two-master, single-slave memory arbiter that shares the core's one memory port between requesters.
- Master 0 is the z_core control unit (fetch and load/store); master 1 is a DMA/debug loader.
- Round-robin arbitration, one outstanding access at a time, fixed memory latency.
- Sits between the requesters and the unified instruction/data memory.

Parameters:
- ADDR_WIDTH, 32, address width of masters and memory.
- DATA_WIDTH, 32, data width.
- MEM_LATENCY, 1, cycles from address presented to mem_data_in valid. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- m0_req  in  1  master 0 access request; held until m0_ready.
- m0_we  in  1  master 0 write enable (1 = write).
- m0_addr  in  ADDR_WIDTH  master 0 byte address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_rdata  out  DATA_WIDTH  master 0 read data, valid when m0_ready.
- m0_ready  out  1  one-cycle completion pulse for master 0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ready  same as m0_*, for master 1.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_data_out  out  DATA_WIDTH  memory write data.
- mem_write_en  out  1  memory write strobe.
- mem_data_in  in  DATA_WIDTH  memory read data.

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - reset==0 sampled at an edge forces state=IDLE, last_grant=1 (so master 0 wins the first tie), cnt=0.
  - All outputs reset to 0: mX_ready, mX_rdata, mem_addr, mem_data_out, mem_write_en.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no mX_req is asserted, stay in IDLE.
  - If exactly one mX_req is asserted, grant that master.
  - If both are asserted, grant the master ≠ last_grant.
  - On grant, latch sel, addr, wdata and we from the granted master; set last_grant=sel, cnt=MEM_LATENCY-1; next state ACCESS.
- ACCESS:
  - mem_addr and mem_data_out are driven from the latched values.
  - mem_write_en = latched we on the first ACCESS cycle only, 0 afterwards. Exactly one write strobe per write.
  - If cnt==0: capture mem_data_in into the sel master's rdata register (reads only; for writes rdata keeps its previous value); next state RESP.
  - Otherwise cnt decrements.
- RESP:
  - m<sel>_ready=1 for exactly one cycle; the other ready stays 0.
  - mem_write_en=0; next state IDLE.
- Latency: a request first seen in IDLE at cycle N completes with ready high at cycle N+MEM_LATENCY+1. Throughput is one access per MEM_LATENCY+2 cycles.
- Handshake rules:
  - A master holds req, we, addr and wdata stable until ready. Changes after the grant are ignored because the values are latched.
  - A req still high in the cycle after ready is a new request, arbitrated in the next IDLE.
  - The non-granted master waits; its ready stays 0.
- Fairness: with both masters requesting continuously, grants strictly alternate 0,1,0,1,... No master waits more than one access.
- mX_rdata holds its last captured value until the next read completion for that master.
- mem_addr and mem_data_out hold their last values in IDLE and RESP; only mem_write_en is guaranteed 0 there.
- Reset mid-operation: an in-flight access is abandoned. No ready pulse, no further mem_write_en. Requesters must re-issue.
- Address and data pass through unmodified; no width conversion and no alignment checking.

Optional Feature:
- Macro: Z_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_grant0 and perf_grant1 (32 bits each) and perf_conflict (32 bits).
  - perf_grantX increments on each grant to master X.
  - perf_conflict increments on each IDLE cycle where both req are high and a grant is made.
  - All three counters reset to 0, wrap modulo 2^32, and update in the same cycle as the grant.
- When undefined: these ports and registers do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Reset: hold reset=0 for 2 cycles with both req=1 -> all outputs 0. After release, the first grant goes to m0 (tie, last_grant=1).
- Single read, MEM_LATENCY=1: m0 reads addr 0x0000_0010 with mem returning 0x0030_0113 -> mem_addr=0x10 in ACCESS, m0_ready pulses at N+2 with m0_rdata=0x0030_0113, m1_ready=0.
- Single write: m1 writes 0xDEAD_BEEF to 0x200 -> mem_write_en high exactly one cycle with mem_addr=0x200 and mem_data_out=0xDEAD_BEEF, then m1_ready pulses.
- Contention: both req held high for 6 accesses -> grant order 0,1,0,1,0,1 and each ready pulse spaced MEM_LATENCY+2 cycles apart.
- MEM_LATENCY=3: m0 read -> m0_ready exactly 4 cycles after the request is seen in IDLE; mem_write_en stays 0 throughout.
- Reset mid-ACCESS: assert reset during an m1 write's ACCESS -> no ready pulse and no second mem_write_en. With Z_ARB_PERF_EN defined, all perf counters read 0 afterwards.

Source files
------------

// File: rtl/z_core_mem_arbiter.sv
// Round-robin two-master arbiter onto the core's single memory port.
// Optional perf counters enabled by defining Z_ARB_PERF_EN.
module z_core_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ready,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_data_in
`ifdef Z_ARB_PERF_EN
    ,
    output logic [31:0]           perf_grant0,
    output logic [31:0]           perf_grant1,
    output logic [31:0]           perf_conflict
`endif
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_sel;
    logic                  r_last;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic [CW-1:0]         r_cnt;
    logic                  w_grant;
    logic                  w_gsel;
    logic                  w_both;
    logic                  w_cnt_done;

    assign w_both     = m0_req & m1_req;
    assign w_cnt_done = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_grant      = 1'b0;
        w_gsel       = 1'b0;
        mem_write_en = 1'b0;
        m0_ready     = 1'b0;
        m1_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (m0_req | m1_req) begin
                    w_grant = 1'b1;
                    // On a tie the master that did not win last time goes
                    w_gsel  = w_both ? ~r_last : m1_req;
                    w_next  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_write_en = r_we
                    && (r_cnt == CW'(MEM_LATENCY - 1));
                if (w_cnt_done) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                m0_ready = ~r_sel;
                m1_ready = r_sel;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sel    <= 1'b0;
            r_last   <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_grant) begin
                r_sel   <= w_gsel;
                r_last  <= w_gsel;
                r_we    <= w_gsel ? m1_we : m0_we;
                r_addr  <= w_gsel ? m1_addr : m0_addr;
                r_wdata <= w_gsel ? m1_wdata : m0_wdata;
                r_cnt   <= CW'(MEM_LATENCY - 1);
            end
            if (r_state == S_ACCESS) begin
                if (w_cnt_done) begin
                    if (!r_we && !r_sel) r_rdata0 <= mem_data_in;
                    if (!r_we && r_sel)  r_rdata1 <= mem_data_in;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end
    end

    assign mem_addr     = r_addr;
    assign mem_data_out = r_wdata;
    assign m0_rdata     = r_rdata0;
    assign m1_rdata     = r_rdata1;

`ifdef Z_ARB_PERF_EN
    logic [31:0] r_perf_g0;
    logic [31:0] r_perf_g1;
    logic [31:0] r_perf_cf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_g0 <= '0;
            r_perf_g1 <= '0;
            r_perf_cf <= '0;
        end else if (w_grant) begin
            if (!w_gsel) r_perf_g0 <= r_perf_g0 + 32'd1;
            if (w_gsel)  r_perf_g1 <= r_perf_g1 + 32'd1;
            if (w_both)  r_perf_cf <= r_perf_cf + 32'd1;
        end
    end

    assign perf_grant0   = r_perf_g0;
    assign perf_grant1   = r_perf_g1;
    assign perf_conflict = r_perf_cf;
`endif

endmodule

// File: tb/tb_z_core_mem_arbiter.sv
// Scoreboard bench: DUT 0 at MEM_LATENCY=1, DUT 1 at MEM_LATENCY=3.
module tb_z_core_mem_arbiter;

    typedef struct {
        int          d;
        int          m;
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        req   [2][2];
    logic        we_i  [2][2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic [31:0] rdata [2][2];
    logic        rdy   [2][2];
    logic [31:0] maddr [2];
    logic [31:0] mdout [2];
    logic [31:0] mdin  [2];
    logic        mwe   [2];
`ifdef Z_ARB_PERF_EN
    logic [31:0] pg0 [2];
    logic [31:0] pg1 [2];
    logic [31:0] pcf [2];
`endif

    exp_t        q[$];
    int          vec_n = 0;
    int          err_n = 0;
    int          cyc = 0;
    int          rdy_n [2] = '{0, 0};
    int          wr_n  [2] = '{0, 0};
    logic [31:0] wr_addr [2];
    logic [31:0] wr_data [2];
    bit          space_en = 1'b0;
    int          prev_rdy = -1;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h10) return 32'h0030_0113;
        return (a ^ 32'h5A5A_0000) + 32'd7;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mdin[0] = mem_f(maddr[0]);
    assign mdin[1] = mem_f(maddr[1]);

    z_core_mem_arbiter #(.MEM_LATENCY(1)) u_dut0 (
        .clk(clk), .reset(rst_n[0]),
        .m0_req(req[0][0]), .m0_we(we_i[0][0]),
        .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
        .m0_rdata(rdata[0][0]), .m0_ready(rdy[0][0]),
        .m1_req(req[0][1]), .m1_we(we_i[0][1]),
        .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
        .m1_rdata(rdata[0][1]), .m1_ready(rdy[0][1]),
        .mem_addr(maddr[0]), .mem_data_out(mdout[0]),
        .mem_write_en(mwe[0]), .mem_data_in(mdin[0])
`ifdef Z_ARB_PERF_EN
        , .perf_grant0(pg0[0]), .perf_grant1(pg1[0]),
        .perf_conflict(pcf[0])
`endif
    );

    z_core_mem_arbiter #(.MEM_LATENCY(3)) u_dut1 (
        .clk(clk), .reset(rst_n[1]),
        .m0_req(req[1][0]), .m0_we(we_i[1][0]),
        .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
        .m0_rdata(rdata[1][0]), .m0_ready(rdy[1][0]),
        .m1_req(req[1][1]), .m1_we(we_i[1][1]),
        .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
        .m1_rdata(rdata[1][1]), .m1_ready(rdy[1][1]),
        .mem_addr(maddr[1]), .mem_data_out(mdout[1]),
        .mem_write_en(mwe[1]), .mem_data_in(mdin[1])
`ifdef Z_ARB_PERF_EN
        , .perf_grant0(pg0[1]), .perf_grant1(pg1[1]),
        .perf_conflict(pcf[1])
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vec_n++;
        if (got !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every ready pulse pops one expected completion
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (mwe[d] === 1'b1) begin
                wr_n[d]++;
                wr_addr[d] = maddr[d];
                wr_data[d] = mdout[d];
            end
            if (rdy[d][0] === 1'b1 || rdy[d][1] === 1'b1) begin
                rdy_n[d]++;
                chk("rdy_pair", rdy[d][0] & rdy[d][1], 0);
                if (q.size() == 0) begin
                    chk("unexp_rdy", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    chk("dut", d, e.d);
                    chk("master", rdy[d][1], e.m);
                    if (!e.we) chk("rdata", rdata[d][e.m], e.data);
                end
                if (space_en && prev_rdy >= 0)
                    chk("space", cyc - prev_rdy, 3);
                prev_rdy = cyc;
            end
        end
    end

    task automatic acc(input int d, input int m, input logic w,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int lat);
        int c0;
        bit got;
        @(posedge clk); #1;
        req[d][m]   = 1'b1;
        we_i[d][m]  = w;
        addr[d][m]  = a;
        wdata[d][m] = wd;
        q.push_back('{d, m, w, w ? 32'h0 : mem_f(a)});
        c0 = cyc;
        @(posedge clk); #1;
        chk("acc_addr", maddr[d], a);
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            got = (rdy[d][m] === 1'b1);
        end
        if (!got) chk("timeout", got, 1);
        else      chk("latency", cyc - c0, lat + 1);
        @(posedge clk); #1;
        req[d][m] = 1'b0;
    endtask

    initial begin
        int n0;
        int r0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                req[d][m]   = 1'b0;
                we_i[d][m]  = 1'b0;
                addr[d][m]  = '0;
                wdata[d][m] = '0;
            end
        end
        req[0][0]  = 1'b1;
        addr[0][0] = 32'h40;
        req[0][1]  = 1'b1;
        addr[0][1] = 32'h80;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdy0", rdy[d][0], 0);
            chk("rst_rdy1", rdy[d][1], 0);
            chk("rst_rdata0", rdata[d][0], 0);
            chk("rst_rdata1", rdata[d][1], 0);
            chk("rst_maddr", maddr[d], 0);
            chk("rst_mdout", mdout[d], 0);
            chk("rst_mwe", mwe[d], 0);
        end

        for (int i = 0; i < 6; i++)
            q.push_back('{0, i % 2, 1'b0,
                          mem_f((i % 2) ? 32'h80 : 32'h40)});
        space_en = 1'b1;
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        for (int k = 0; k < 60 && rdy_n[0] < 6; k++) begin
            @(negedge clk); #1;
        end
        chk("cont_cnt", rdy_n[0], 6);
        chk("cont_q", q.size(), 0);
        @(posedge clk); #1;
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        space_en  = 1'b0;

        acc(0, 0, 1'b0, 32'h10, 32'h0, 1);
        chk("m0_rdata", rdata[0][0], 32'h0030_0113);
        n0 = wr_n[0];
        acc(0, 1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1);
        chk("wr_cnt", wr_n[0] - n0, 1);
        chk("wr_addr", wr_addr[0], 32'h200);
        chk("wr_data", wr_data[0], 32'hDEAD_BEEF);
        chk("m1_hold", rdata[0][1], mem_f(32'h80));
`ifdef Z_ARB_PERF_EN
        chk("perf_g0", pg0[0], 4);
        chk("perf_g1", pg1[0], 4);
        chk("perf_cf", pcf[0], 6);
`endif

        n0 = wr_n[1];
        acc(1, 0, 1'b0, 32'h1234, 32'h0, 3);
        chk("b_no_we", wr_n[1] - n0, 0);
        acc(1, 0, 1'b1, 32'h300, 32'h55AA, 3);
        chk("b_wr_cnt", wr_n[1] - n0, 1);
        chk("b_wr_data", wr_data[1], 32'h55AA);
        chk("b_m0_hold", rdata[1][0], mem_f(32'h1234));

        n0 = wr_n[1];
        r0 = rdy_n[1];
        @(posedge clk); #1;
        req[1][1]   = 1'b1;
        we_i[1][1]  = 1'b1;
        addr[1][1]  = 32'h400;
        wdata[1][1] = 32'hCAFE;
        repeat (2) @(posedge clk);
        #1;
        rst_n[1]  = 1'b0;
        req[1][1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        chk("mid_rdy", rdy_n[1] - r0, 0);
        chk("mid_wr", wr_n[1] - n0, 1);
        chk("mid_rdata1", rdata[1][1], 0);
`ifdef Z_ARB_PERF_EN
        chk("mid_pg0", pg0[1], 0);
        chk("mid_pg1", pg1[1], 0);
        chk("mid_pcf", pcf[1], 0);
`endif
        chk("end_q", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_n, err_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

endmodule
